// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and mem_acc_mode encodings for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;
  localparam logic [2:0] MEM_BYTE   = 3'b000;
  localparam logic [2:0] MEM_HALF   = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_BYTE_U = 3'b100;
  localparam logic [2:0] MEM_HALF_U = 3'b101;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner select, fixed LS>IF priority or round robin when ARB_ROUND_ROBIN_EN is defined
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  arb_owner_e last_owner,
  output arb_owner_e pick
);
`ifdef ARB_ROUND_ROBIN_EN
  always_comb pick = !ls_req ? OWN_IF : !if_req ? OWN_LS : last_owner == OWN_LS ? OWN_IF : OWN_LS;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner == OWN_LS;
  always_comb pick = (ls_req || !if_req) ? OWN_LS : OWN_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and LS with request/response sequencing and a response watchdog
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [2:0]        ls_mode,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_mode,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  arb_state_e        state, state_nx;
  arb_owner_e        owner, last_owner, pick;
  logic [TW-1:0]     timer;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_mode;
  logic              any_req, is_ls, acc, resp, tmo, done;
  mem_arb_pick u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .last_owner (last_owner),
    .pick       (pick)
  );
  assign any_req = if_req || ls_req;
  assign is_ls   = owner == OWN_LS;
  assign acc     = state == REQ && mem_gnt;
  assign resp    = state == RESP && mem_rvalid;
  assign tmo     = state == RESP && !mem_rvalid && timer == TW'(TIMEOUT - 1);
  assign done    = resp || tmo;
  always_comb begin
    state_nx  = state == IDLE ? (any_req ? REQ : IDLE) :
                state == REQ  ? (mem_gnt ? RESP : REQ) :
                                (done ? IDLE : RESP);
    mem_req   = state == REQ;
    mem_we    = mem_req && cmd_we;
    mem_addr  = mem_req ? cmd_addr : '0;
    mem_wdata = mem_req ? cmd_wdata : '0;
    mem_mode  = mem_req ? cmd_mode : 3'b000;
    if_gnt    = acc && !is_ls;
    ls_gnt    = acc && is_ls;
    if_rvalid = done && !is_ls;
    ls_rvalid = done && is_ls;
    if_err    = tmo && !is_ls;
    ls_err    = tmo && is_ls;
    if_rdata  = (resp && !is_ls) ? mem_rdata : '0;
    ls_rdata  = (resp && is_ls) ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      timer      <= '0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_mode   <= 3'b000;
    end else begin
      state <= state_nx;
      timer <= acc ? '0 : state == RESP ? timer + 1'b1 : timer;
      if (resp) last_owner <= owner;
      if (state == IDLE && any_req) begin
        owner     <= pick;
        cmd_we    <= pick == OWN_LS && ls_we;
        cmd_addr  <= pick == OWN_LS ? ls_addr : if_addr;
        cmd_wdata <= pick == OWN_LS ? ls_wdata : '0;
        cmd_mode  <= pick == OWN_LS ? ls_mode : MEM_WORD;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter against a transaction-level reference model
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int TO = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [2:0]  ls_mode = 3'b000;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  int          checks = 0, failures = 0;
  bit          m_last = 1'b0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mode(ls_mode),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_ctl"}, {24'd0, if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we}, 32'd0);
    chk({tag, "_data"}, if_rdata | ls_rdata | mem_addr | mem_wdata | {29'd0, mem_mode}, 32'd0);
  endtask
  function automatic bit pick_ls(input bit i, input bit l);
    if (!i) return 1'b1;
    if (!l) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return m_last == 1'b0;
`else
    return 1'b1;
`endif
  endfunction
  task automatic txn(input int gd, input int rd, input logic [31:0] rdat, input bit stray);
    bit w, ok, to;
    logic [31:0] ea, ew, d;
    logic [2:0] em;
    logic we;
    int last;
    w  = pick_ls(if_req, ls_req);
    ea = w ? ls_addr : if_addr;
    we = w && ls_we;
    ew = w ? ls_wdata : 32'd0;
    em = w ? ls_mode : MEM_WORD;
    mem_gnt = 1'b0;
    mem_rvalid = stray;
    #1 quiet("idle");
    @(posedge clk);
    for (int k = 0; k <= gd; k++) begin
      @(negedge clk);
      mem_gnt = k == gd;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      chk("mem_req", {31'd0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", {31'd0, mem_we}, {31'd0, we});
      chk("mem_wdata", mem_wdata, ew);
      chk("mem_mode", {29'd0, mem_mode}, {29'd0, em});
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, !w && k == gd});
      chk("ls_gnt", {31'd0, ls_gnt}, {31'd0, w && k == gd});
      chk("req_rsp_quiet", {28'd0, if_rvalid, ls_rvalid, if_err, ls_err}, 32'd0);
      @(posedge clk);
    end
    last = rd < TO ? rd : TO - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (w) ls_req = 1'b0;
        else if_req = 1'b0;
      end
      d = (k == rd) ? rdat : $urandom;
      mem_gnt = 1'b0;
      mem_rvalid = k == rd;
      mem_rdata = d;
      ok = k == rd;
      to = !ok && k == TO - 1;
      #1;
      chk("mem_req_resp", {31'd0, mem_req}, 32'd0);
      chk("gnt_resp", {30'd0, if_gnt, ls_gnt}, 32'd0);
      chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, !w && (ok || to)});
      chk("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, w && (ok || to)});
      chk("if_err", {31'd0, if_err}, {31'd0, !w && to});
      chk("ls_err", {31'd0, ls_err}, {31'd0, w && to});
      chk("if_rdata", if_rdata, (!w && ok) ? d : 32'd0);
      chk("ls_rdata", ls_rdata, (w && ok) ? d : 32'd0);
      if (ok) m_last = w;
      @(posedge clk);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask
  task automatic new_reqs(input bit both);
    if (!if_req && (both || $urandom_range(0, 1) == 1)) begin
      if_req = 1'b1;
      if_addr = $urandom;
    end
    if (!ls_req && (both || $urandom_range(0, 1) == 1)) begin
      ls_req = 1'b1;
      ls_we = 1'($urandom_range(0, 1));
      ls_addr = $urandom;
      ls_wdata = $urandom;
      ls_mode = 3'($urandom_range(0, 7));
    end
    if (!if_req && !ls_req) begin
      if_req = 1'b1;
      if_addr = $urandom;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1;
    #1 quiet("reset");
    rst = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h100;
    txn(0, 1, 32'hDEADBEEF, 1'b0);
    if_req = 1'b1;
    if_addr = 32'h300;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 32'h400;
    ls_mode = MEM_HALF;
    txn(0, 0, $urandom, 1'b0);
    txn(1, 2, $urandom, 1'b0);
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = 32'h2000;
    ls_wdata = 32'h12345678;
    ls_mode = MEM_WORD;
    txn(3, 0, 32'd0, 1'b0);
    if_req = 1'b1;
    if_addr = 32'h500;
    txn(0, 100, 32'd0, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    #1 quiet("stray_idle");
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 32'h600;
    ls_mode = MEM_BYTE_U;
    txn(20, 4, $urandom, 1'b0);
    if_req = 1'b1;
    if_addr = 32'h700;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1;
    #1 quiet("rst_mid");
    rst = 1'b0;
    m_last = 1'b0;
    txn(0, 1, $urandom, 1'b1);
    for (int n = 0; n < 20; n++) begin
      new_reqs(1'b1);
      txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom, 1'b0);
    end
    for (int n = 0; n < 150; n++) begin
      new_reqs(1'b0);
      txn(int'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 5)),
          $urandom, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
